seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 alu_func  input  4  operation code, one of the shared OP_* codes.
REQ-007 in_a  input  XLEN  operand A (rs1).
REQ-008 in_b  input  XLEN  operand B (rs2 or immediate); shift amount is in_b[4:0].
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  XLEN  operation result.
REQ-012 check  output  1  branch condition outcome.
REQ-013 error  output  1  request carried an unsupported alu_func.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-016 alu_func, in_a and in_b SHALL be captured at acceptance, and later input changes SHALL NOT affect the result.
REQ-017 Non-shift ops SHALL use IDLE->DONE, so out_valid rises the cycle after acceptance (latency 1).
REQ-018 OP_SLL, OP_SRL and OP_SRA SHALL shift iteratively by one bit per cycle.
REQ-019 A shift with shamt=0 SHALL go to DONE at latency 1; otherwise it SHALL go IDLE->SHIFT and then SHIFT->DONE after shamt cycles (latency 1+shamt, maximum 32).
REQ-020 OP_SRA SHALL replicate the original bit 31 on every step, and OP_SRL SHALL shift in zeros.
REQ-021 Result rules, all modulo 2^32:
- ADD: a+b.
- SUB: a-b.
- XOR, OR, AND: bitwise.
- SLT: signed a<b, zero-extended.
- SLTU: unsigned a<b, zero-extended.
- BGE: signed a>=b, zero-extended.
- BGEU: unsigned a>=b, zero-extended.
REQ-022 check rules:
- SUB: a==b.
- ADD: a!=b.
- SLT: signed a<b.
- SLTU: unsigned a<b.
- BGE: signed a>=b.
- BGEU: unsigned a>=b.
- All shifts and logic ops: 0.
REQ-023 OP_EEE or any unlisted code SHALL complete at latency 1 with result=0, check=0 and error=1; otherwise error=0.
REQ-024 In DONE, out_valid=1 and result, check and error SHALL hold stable until out_ready=1.
REQ-025 On the out_valid and out_ready handshake the FSM SHALL return to IDLE, so in_ready rises the following cycle.
REQ-026 There SHALL be no acceptance in the handshake cycle (maximum one request in flight).
REQ-027 In IDLE and SHIFT, out_valid SHALL be 0, and result, check and error SHALL retain their last values.

Reset
REQ-028 Asserting reset at any time, including mid-shift or in DONE, SHALL force IDLE, result=0, check=0, error=0, out_valid=0 and in_ready=1, and the in-flight request SHALL be discarded.
REQ-029 The first acceptance after reset SHALL be possible on the first rising edge with reset deasserted.

Structure
REQ-030 The OP_* codes (OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_BGE, OP_BGEU, OP_EEE) SHALL come from the shared defines file and SHALL NOT be redefined locally.
REQ-031 The FSM state encodings SHALL be local to seq_alu.
REQ-032 The iterative shifter SHALL be one sub-module, seq_shifter, with load/step/busy signals, instantiated once.

Verification
REQ-033 ADD a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after acceptance, result=0x00000000, check=1, error=0.
REQ-034 SRA a=0x80000000, b=31 -> out_valid 32 cycles after acceptance, result=0xFFFFFFFF, in_ready=0 throughout.
REQ-035 SLL a=0x1, b=0 -> latency 1, result=0x1; SRL a=0x80000000, b=4 -> latency 5, result=0x08000000.
REQ-036 Branch and error cases:
- BGE a=0xFFFFFFFE, b=1 -> check=0, result=0.
- BGEU with the same operands -> check=1, result=1.
- alu_func=OP_EEE -> error=1, result=0.
REQ-037 Backpressure: SUB a=5, b=5 with out_ready=0 for 4 cycles -> result=0 and check=1 held stable, in_ready=0; out_ready=1 -> in_ready=1 the next cycle.
REQ-038 Reset pulse 3 cycles into SRL a=0xF0, b=10 -> out_valid=0 and result=0 immediately; a next request of XOR 0xF0^0x0F completes with result=0xFF.

Source files
------------

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu_pkg : shared OP_* codes, shift modes and single-cycle ALU evaluation
// Revision    : 1.0
// ---------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_BGE  = 4'hA;
  localparam logic [3:0] OP_BGEU = 4'hB;
  localparam logic [3:0] OP_EEE  = 4'hF;

  localparam int c_shamt_w = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

  typedef struct packed {
    logic [31:0] result;
    logic        check;
    logic        error;
  } alu_out_t;

  function automatic logic is_shift_op(input logic [3:0] func);
    return (func == OP_SLL) || (func == OP_SRL) || (func == OP_SRA);
  endfunction

  // Shift ops return operand A unchanged: only the zero-shift case uses this path.
  function automatic alu_out_t alu_eval(input logic [3:0]  func,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    alu_out_t r;
    logic     lt;
    logic     ltu;
    logic     eq;
    r   = '0;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    eq  = a == b;
    case (func)
      OP_ADD:  begin r.result = a + b; r.check = !eq; end
      OP_SUB:  begin r.result = a - b; r.check = eq;  end
      OP_XOR:  r.result = a ^ b;
      OP_OR:   r.result = a | b;
      OP_AND:  r.result = a & b;
      OP_SLL, OP_SRL, OP_SRA: r.result = a;
      OP_SLT:  begin r.result = {31'b0, lt};   r.check = lt;   end
      OP_SLTU: begin r.result = {31'b0, ltu};  r.check = ltu;  end
      OP_BGE:  begin r.result = {31'b0, !lt};  r.check = !lt;  end
      OP_BGEU: begin r.result = {31'b0, !ltu}; r.check = !ltu; end
      default: r.error = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_shifter : one-bit-per-cycle shifter; load performs the first step
// Revision    : 1.0
// ---------------------------------------------------------------------------
module seq_shifter
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  shift_mode_e          mode,
  input  logic [XLEN-1:0]      din,
  input  logic [c_shamt_w-1:0] shamt,
  output logic                 busy,
  output logic [XLEN-1:0]      dout
);

  logic [XLEN-1:0]      r_data;
  logic [c_shamt_w-1:0] r_cnt;
  shift_mode_e          r_mode;
  logic                 r_sign;

  function automatic logic [XLEN-1:0] shift1(input shift_mode_e     m,
                                             input logic            sign,
                                             input logic [XLEN-1:0] d);
    case (m)
      SH_SLL:  return {d[XLEN-2:0], 1'b0};
      SH_SRL:  return {1'b0, d[XLEN-1:1]};
      default: return {sign, d[XLEN-1:1]};
    endcase
  endfunction

  // Loading applies one step immediately, so a shamt of N is done N-1 steps later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_mode <= SH_SLL;
      r_sign <= 1'b0;
    end else if (load) begin
      r_data <= shift1(mode, din[XLEN-1], din);
      r_cnt  <= shamt - c_shamt_w'(1);
      r_mode <= mode;
      r_sign <= din[XLEN-1];
    end else if (step && busy) begin
      r_data <= shift1(r_mode, r_sign, r_data);
      r_cnt  <= r_cnt - c_shamt_w'(1);
    end
  end

  assign busy = (r_cnt != '0);
  assign dout = r_data;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu  : handshaked ALU with iterative shifts and branch-condition output
// Revision : 1.0
// ---------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_func,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            check,
  output logic            error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic            w_accept;
  logic            w_sh_load;
  logic            w_sh_busy;
  logic [XLEN-1:0] w_sh_dout;
  shift_mode_e     w_mode;
  alu_out_t        w_eval;
  logic [XLEN-1:0] r_result;
  logic            r_check;
  logic            r_error;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_sh_load = w_accept && is_shift_op(alu_func) && (in_b[c_shamt_w-1:0] != '0);
  assign w_eval    = alu_eval(alu_func, in_a, in_b);

  always_comb begin
    case (alu_func)
      OP_SLL:  w_mode = SH_SLL;
      OP_SRL:  w_mode = SH_SRL;
      default: w_mode = SH_SRA;
    endcase
  end

  seq_shifter #(.XLEN(XLEN)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (w_sh_load),
    .step  (r_state == SHIFT),
    .mode  (w_mode),
    .din   (in_a),
    .shamt (in_b[c_shamt_w-1:0]),
    .busy  (w_sh_busy),
    .dout  (w_sh_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_sh_load ? SHIFT : DONE;
      end
      SHIFT: begin
        if (!w_sh_busy) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Result registers only move on completion, so they hold through IDLE and SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_check  <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_accept && !w_sh_load) begin
      r_result <= w_eval.result;
      r_check  <= w_eval.check;
      r_error  <= w_eval.error;
    end else if ((r_state == SHIFT) && !w_sh_busy) begin
      r_result <= w_sh_dout;
      r_check  <= 1'b0;
      r_error  <= 1'b0;
    end
  end

  assign result = r_result;
  assign check  = r_check;
  assign error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_alu : directed and randomized bench for seq_alu with reference model
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        check;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_func  (alu_func),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .check     (check),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {error, check, result} straight from the arithmetic rules.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        e;
    int          sh;
    r = 0; c = 0; e = 0; sh = int'(b[4:0]);
    case (op)
      OP_ADD:  begin r = a + b; c = (a != b); end
      OP_SUB:  begin r = a - b; c = (a == b); end
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = 32'($signed(a) >>> sh);
      OP_SLT:  begin c = ($signed(a) < $signed(b));  r = {31'b0, c}; end
      OP_SLTU: begin c = (a < b);                    r = {31'b0, c}; end
      OP_BGE:  begin c = ($signed(a) >= $signed(b)); r = {31'b0, c}; end
      OP_BGEU: begin c = (a >= b);                   r = {31'b0, c}; end
      default: e = 1;
    endcase
    return {e, c, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && b[4:0] != 0)
      return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [33:0] m;
    int          lat;
    bit          seen;
    bit          rdy_busy;
    m = model(op, a, b);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1; alu_func = op; in_a = a; in_b = b; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; alu_func = 4'($urandom); in_a = $urandom; in_b = $urandom;
    lat = 0; seen = 0; rdy_busy = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; lat = i; end
      else if (in_ready) rdy_busy = 1;
    end
    chk({tag, ".out_valid_seen"}, seen, 1);
    chk({tag, ".latency"}, lat, exp_lat(op, b));
    chk({tag, ".in_ready_busy"}, rdy_busy, 0);
    chk({tag, ".result"}, result, m[31:0]);
    chk({tag, ".check"}, check, m[32]);
    chk({tag, ".error"}, error, m[33]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".held_valid"}, out_valid, 1);
      chk({tag, ".held_ready"}, in_ready, 0);
      chk({tag, ".held_result"}, {result[30:0], check}, {m[30:0], m[32]});
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_ready"}, in_ready, 1);
    chk({tag, ".post_result"}, result, m[31:0]);
    @(negedge clk);
  endtask

  logic [3:0] op_tbl [16];

  initial begin
    reset = 1; in_valid = 0; alu_func = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.result", result, 0);
    chk("reset.flags", {check, error}, 0);
    reset = 0;

    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 0);
    run_op("sll0", OP_SLL, 32'h1, 32'd0, 0);
    run_op("srl4", OP_SRL, 32'h8000_0000, 32'd4, 1);
    run_op("bge", OP_BGE, 32'hFFFF_FFFE, 32'h1, 0);
    run_op("bgeu", OP_BGEU, 32'hFFFF_FFFE, 32'h1, 0);
    run_op("eee", OP_EEE, 32'h1234_5678, 32'h9, 0);
    run_op("sub_bp", OP_SUB, 32'd5, 32'd5, 4);
    run_op("sll1", OP_SLL, 32'h8000_0001, 32'd1, 0);

    // Reset three cycles into a long shift discards it.
    in_valid = 1; alu_func = OP_SRL; in_a = 32'hF0; in_b = 32'd10;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_shift.out_valid", out_valid, 0);
    chk("rst_shift.result", result, 0);
    chk("rst_shift.in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    run_op("xor_after_rst", OP_XOR, 32'hF0, 32'h0F, 0);

    // Reset while holding a completed result.
    in_valid = 1; alu_func = OP_SLTU; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 0;
    chk("rst_done.pre_valid", out_valid, 1);
    chk("rst_done.pre_check", check, 1);
    #2 reset = 1;
    #1;
    chk("rst_done.out_valid", out_valid, 0);
    chk("rst_done.result", result, 0);
    chk("rst_done.flags", {check, error}, 0);
    chk("rst_done.in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;

    op_tbl = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA,
               OP_SLT, OP_SLTU, OP_BGE, OP_BGEU, OP_EEE, 4'hC, 4'hD, 4'hE};
    for (int k = 0; k < 30; k++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = op_tbl[$urandom_range(0, 15)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op == OP_SLT && k[0]) a[31] = ~b[31];
      run_op($sformatf("rand%0d", k), op, a, b, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
